// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stage indices and sequencer state type for pipe_ctrl
// Purpose: stage numbering of the StallBus/FlushBus and the multi-cycle FSM state enum.
// Ports: none (package).
package pipe_ctrl_pkg;

  localparam int STAGE_PC  = 0;
  localparam int STAGE_IF  = 1;
  localparam int STAGE_ID  = 2;
  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;
  localparam int STAGE_WB  = 5;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stall/flush controller bus between the core stages and pipe_ctrl
// Purpose: bundles stall requests, multi-cycle op handshake, flush/redirect and perf/watchdog.
// Ports (master = core side, slave = pipe_ctrl):
//   stallreq, mc_start, mc_len, flush_req, flush_pc, perf_clr  master -> slave
//   mc_done, stall, flush, redirect_en, redirect_pc,
//   stall_cycles, hang                                         slave -> master
interface pipe_ctrl_if #(
  parameter int NSTAGE = 6,
  parameter int LEN_W  = 6,
  parameter int PC_W   = 32,
  parameter int PERF_W = 32
);
  logic [NSTAGE-1:0] stallreq;
  logic              mc_start;
  logic [LEN_W-1:0]  mc_len;
  logic              mc_done;
  logic              flush_req;
  logic [PC_W-1:0]   flush_pc;
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] flush;
  logic              redirect_en;
  logic [PC_W-1:0]   redirect_pc;
  logic              perf_clr;
  logic [PERF_W-1:0] stall_cycles;
  logic              hang;

  modport master (
    output stallreq, mc_start, mc_len, flush_req, flush_pc, perf_clr,
    input  mc_done, stall, flush, redirect_en, redirect_pc, stall_cycles, hang
  );

  modport slave (
    input  stallreq, mc_start, mc_len, flush_req, flush_pc, perf_clr,
    output mc_done, stall, flush, redirect_en, redirect_pc, stall_cycles, hang
  );
endinterface

// File: rtl/pipe_ctrl_mc_seq.sv
// rtl/pipe_ctrl_mc_seq.sv - EX multi-cycle op sequencer (IDLE/BUSY FSM with down-counter)
// Purpose: stalls EX for an op of mc_len cycles and pulses mc_done on its final cycle.
// Ports:
//   clk, rst            clock, async active-low reset
//   start, len          op start request and total EX occupancy in cycles
//   abort               flush in progress: drop any op, ignore start, no done
//   mc_stall, mc_done   EX stall request / final-cycle pulse (combinational)
module pipe_ctrl_mc_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             mc_stall,
  output logic             mc_done
);

  mc_state_t        state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt holds the cycles left until (and including) the done cycle;
  // the done cycle is reached when it reads 1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    mc_done  = 1'b0;
    case (state_q)
      MC_IDLE: begin
        if (start && !abort) begin
          if (len <= LEN_W'(1)) begin
            mc_done = 1'b1;
          end else begin
            mc_stall = 1'b1;
            cnt_d    = len - LEN_W'(1);
            state_d  = MC_BUSY;
          end
        end
      end
      MC_BUSY: begin
        if (abort) begin
          state_d = MC_IDLE;
        end else if (cnt_q == LEN_W'(1)) begin
          mc_done = 1'b1;
          state_d = MC_IDLE;
        end else begin
          mc_stall = 1'b1;
          cnt_d    = cnt_q - LEN_W'(1);
        end
      end
      default: state_d = MC_IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with perf counter and hang watchdog
// Purpose: merges stage stall requests into the StallBus, sequences EX multi-cycle ops,
//   issues registered flush/redirect, counts stalled cycles and flags long stalls.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   pipe_ctrl_if slave modport (stall requests, mc handshake, flush, perf, hang)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE    = 6,
  parameter int EX_IDX    = STAGE_EX,
  parameter int FLUSH_IDX = STAGE_MEM,
  parameter int LEN_W     = 6,
  parameter int PC_W      = 32,
  parameter int PERF_W    = 32,
  parameter int TIMEOUT   = 1024
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);
  // Stages 1..FLUSH_IDX-1 are killed; the PC stage is reloaded via redirect instead.
  localparam logic [NSTAGE-1:0] FLUSH_MASK =
    ((NSTAGE'(1) << FLUSH_IDX) - NSTAGE'(1)) & ~NSTAGE'(1);

  logic              mc_stall, mc_done;
  logic              flush_q;
  logic [PC_W-1:0]   pc_q;
  logic [NSTAGE-1:0] req_eff, stall_int;
  logic [PERF_W-1:0] perf_q;
  logic [RUN_W-1:0]  run_q;
  logic              hang_q;

  pipe_ctrl_mc_seq #(.LEN_W(LEN_W)) u_mc_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (bus.mc_start),
    .len      (bus.mc_len),
    .abort    (flush_q),
    .mc_stall (mc_stall),
    .mc_done  (mc_done)
  );

  // A stalled stage freezes every younger stage: stall[i] = OR of req_eff[NSTAGE-1:i].
  // The flush cycle overrides all stalls so the redirect can take effect.
  always_comb begin
    req_eff   = bus.stallreq | (NSTAGE'(mc_stall) << EX_IDX);
    stall_int = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      stall_int[i] = |(req_eff >> i);
    end
    if (flush_q) begin
      stall_int = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      flush_q <= bus.flush_req;
      if (bus.flush_req) begin
        pc_q <= bus.flush_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (bus.perf_clr) begin
      perf_q <= '0;
    end else if (stall_int[0] && (perf_q != '1)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  // hang is raised on the same edge the run count reaches TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q  <= '0;
      hang_q <= 1'b0;
    end else if (!stall_int[0] || flush_q) begin
      run_q <= '0;
    end else if (run_q != RUN_W'(TIMEOUT)) begin
      run_q <= run_q + RUN_W'(1);
      if (run_q == RUN_W'(TIMEOUT - 1)) begin
        hang_q <= 1'b1;
      end
    end
  end

  assign bus.stall        = stall_int;
  assign bus.flush        = flush_q ? FLUSH_MASK : '0;
  assign bus.redirect_en  = flush_q;
  assign bus.redirect_pc  = pc_q;
  assign bus.mc_done      = mc_done;
  assign bus.stall_cycles = perf_q;
  assign bus.hang         = hang_q;

endmodule
